uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Clocked, parametrised successor to the combinational SD-to-UART glue. Accepts transmit words from the SD-side datapath over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Feeds the UART transmitter one word at a time using a start/busy handshake. Holds one received word and publishes a status byte that replaces the loose uart_ctrl bits.

Parameters:
DATA_W, 8, width of the TX/RX data words
DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2
BUSY_TIMEOUT, 16, cycles to wait for uart_tx_busy to rise after a start pulse before declaring an error

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
sd_tx_valid  input  1  SD side presents sd_tx_data
sd_tx_data  input  DATA_W  word to transmit
sd_tx_ready  output  1  FIFO can accept a word
uart_tx_start  output  1  one-cycle start pulse to the UART transmitter
uart_tx_data  output  DATA_W  word for the transmitter; held stable from the start pulse until busy falls
uart_tx_busy  input  1  transmitter is shifting a word
uart_rx_valid  input  1  one-cycle pulse: receiver has a word
uart_rx_data  input  DATA_W  received word
rx_ack  input  1  consumer has read rx_data_out
rx_data_out  output  DATA_W  held received word
status  output  8  {2'b0, tx_err, rx_overrun, fifo_full, fifo_empty, tx_sending, rx_contains_data}
status_wr  output  1  one-cycle pulse in the cycle after any status bit changes

Behaviour:
- Reset values: all outputs 0, except sd_tx_ready=1 and status[2] (fifo_empty)=1. FIFO pointers are cleared. FSM goes to IDLE.
- Reset asserted mid-transfer: in-flight and buffered words are discarded. No start pulse is issued after reset deasserts until new data is written.
- FIFO write: occurs when sd_tx_valid && sd_tx_ready. sd_tx_ready = !full, registered from the current occupancy.
- FIFO read: the FSM reads the head word in IDLE when the FIFO is not empty.
- Simultaneous read and write while full: the write is refused, because ready is already 0. Simultaneous read and write in any other state: occupancy is unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the pointers differ only in the MSB.
- FSM states and transitions:
  IDLE: if the FIFO is not empty, pop the head into uart_tx_data and go to START.
  START: uart_tx_start=1 for exactly one cycle, clear the timeout counter, go to WAIT_BUSY.
  WAIT_BUSY: if uart_tx_busy=1, go to SENDING. If the counter reaches BUSY_TIMEOUT-1, set tx_err (sticky) and go to IDLE; the word is dropped.
  SENDING: tx_sending=1. When uart_tx_busy=0, go to IDLE.
- Latency: a word written into an empty FIFO in cycle N produces uart_tx_start high in cycle N+2.
- Back-to-back words: the minimum gap is 2 cycles from busy falling to the next start pulse.
- RX path: uart_rx_valid loads rx_data_out and sets rx_contains_data.
  - rx_ack clears rx_contains_data.
  - uart_rx_valid while rx_contains_data=1 and no rx_ack overwrites the data and sets rx_overrun (sticky).
  - uart_rx_valid and rx_ack in the same cycle: the new data is loaded, the flag stays 1, and no overrun is raised.
- Sticky bits tx_err and rx_overrun are cleared only by rst.
- status_wr compares the registered status with its previous value. It is never asserted in the first cycle after reset.

Optional Feature:
UART_TX_SCHED_LOOPBACK_EN: adds input port loopback (1 bit).
- When loopback=1, each word handed to the transmitter at its start pulse is also written into the RX holding register in the same cycle, with the same rx_contains_data and overrun rules. The external uart_rx_valid is ignored.
- When loopback=0, or when the macro is undefined, the port is absent (macro undefined) and RX behaves as described above.

Test Plan:
- Reset, then write 8'hA5 with a transmitter model that raises busy 1 cycle after start and holds it 10 cycles -> uart_tx_start high 2 cycles after the write with uart_tx_data=8'hA5; status[1]=1 while busy; status_wr pulses on each status change.
- Write 4 words 01, 02, 03, 04 back-to-back while busy is stuck at 1 -> sd_tx_ready=0 and fifo_full=1 after word 4; a 5th write is refused. After busy is released, the words are transmitted in order 01, 02, 03, 04 and fifo_empty ends at 1.
- Busy never rises after a start -> tx_err=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY is entered, and the FSM returns to IDLE and serves the next word.
- uart_rx_valid with 8'h3C, then 8'h7E with no ack -> rx_data_out=8'h7E and rx_overrun=1. Then rx_valid and rx_ack in the same cycle -> no change to the overrun bit and rx_contains_data stays 1.
- Assert rst while in SENDING with 2 words queued -> all outputs return to their reset values immediately, the FIFO is empty, and no start pulse occurs after deassertion.
- With UART_TX_SCHED_LOOPBACK_EN defined and loopback=1, send 8'h5A -> rx_data_out=8'h5A and rx_contains_data=1 in the cycle after the start pulse.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// TX scheduler between the SD datapath and the UART: DEPTH-entry TX FIFO, start/busy sequencing,
// single-word RX holding register and status byte. Optional macro UART_TX_SCHED_LOOPBACK_EN adds RX loopback.
//
// state     | meaning
// IDLE      | waiting for a word in the FIFO; pops the head when one is present
// START     | uart_tx_start is high for this single cycle
// WAIT_BUSY | waiting for the transmitter to raise busy, bounded by BUSY_TIMEOUT
// SENDING   | transmitter is shifting the word; tx_sending is high
module uart_tx_scheduler #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef UART_TX_SCHED_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              sd_tx_valid,
  input  logic [DATA_W-1:0] sd_tx_data,
  output logic              sd_tx_ready,
  output logic              uart_tx_start,
  output logic [DATA_W-1:0] uart_tx_data,
  input  logic              uart_tx_busy,
  input  logic              uart_rx_valid,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data_out,
  output logic [7:0]        status,
  output logic              status_wr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, SENDING} state_t;

  state_t            state;
  logic [TW-1:0]     busy_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic              wr_en, rd_en, empty_nxt, full_nxt;
  logic              fifo_full, fifo_empty, tx_sending, tx_err;
  logic              rx_contains_data, rx_overrun;
  logic              rx_load;
  logic [DATA_W-1:0] rx_din;
  logic [7:0]        status_q;

  always_comb begin
    wr_en      = sd_tx_valid && sd_tx_ready;
    rd_en      = (state == IDLE) && (wr_ptr != rd_ptr);
    wr_ptr_nxt = wr_ptr + PW'(wr_en);
    rd_ptr_nxt = rd_ptr + PW'(rd_en);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sd_tx_data;
  end

  // Ready and the occupancy flags are registered from the post-update pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sd_tx_ready <= 1'b1;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      sd_tx_ready <= !full_nxt;
      fifo_full   <= full_nxt;
      fifo_empty  <= empty_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy_cnt      <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
      tx_sending    <= 1'b0;
      tx_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en) begin
            uart_tx_data  <= mem[rd_ptr[AW-1:0]];
            uart_tx_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          uart_tx_start <= 1'b0;
          busy_cnt      <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            tx_sending <= 1'b1;
            state      <= SENDING;
          end else if (busy_cnt == CNT_LAST) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        SENDING: begin
          if (!uart_tx_busy) begin
            tx_sending <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_SCHED_LOOPBACK_EN
  // In loopback the word is captured during its start pulse, so it lands the following cycle.
  assign rx_load = loopback ? uart_tx_start : uart_rx_valid;
  assign rx_din  = loopback ? uart_tx_data  : uart_rx_data;
`else
  assign rx_load = uart_rx_valid;
  assign rx_din  = uart_rx_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_out      <= '0;
      rx_contains_data <= 1'b0;
      rx_overrun       <= 1'b0;
    end else if (rx_load) begin
      rx_data_out      <= rx_din;
      rx_contains_data <= 1'b1;
      if (rx_contains_data && !rx_ack) rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      rx_contains_data <= 1'b0;
    end
  end

  assign status = {2'b00, tx_err, rx_overrun, fifo_full, fifo_empty, tx_sending, rx_contains_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= 8'h04;
      status_wr <= 1'b0;
    end else begin
      status_q  <= status;
      status_wr <= (status != status_q);
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: FIFO latency/ordering, busy timeout, RX overrun, reset abort,
// and loopback when UART_TX_SCHED_LOOPBACK_EN is defined.
module tb_uart_tx_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       sd_tx_valid;
  logic [7:0] sd_tx_data;
  logic       sd_tx_ready;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       rx_ack;
  logic [7:0] rx_data_out;
  logic [7:0] status;
  logic       status_wr;
`ifdef UART_TX_SCHED_LOOPBACK_EN
  logic       loopback;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_scheduler #(.DATA_W(8), .DEPTH(4), .BUSY_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef UART_TX_SCHED_LOOPBACK_EN
    .loopback      (loopback),
`endif
    .sd_tx_valid   (sd_tx_valid),
    .sd_tx_data    (sd_tx_data),
    .sd_tx_ready   (sd_tx_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .rx_ack        (rx_ack),
    .rx_data_out   (rx_data_out),
    .status        (status),
    .status_wr     (status_wr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded search for the next start pulse.
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (uart_tx_start) seen = 1'b1;
    end
  endtask

  // Expect the next transmitted word, then play a transmitter that is busy for 3 cycles.
  task automatic expect_tx(input string tag, input logic [7:0] w);
    bit seen;
    wait_start(seen);
    chk({tag, "_start"}, {7'b0, seen}, 8'h01);
    chk({tag, "_data"}, uart_tx_data, w);
    step(1);
    uart_tx_busy = 1'b1;
    step(3);
    uart_tx_busy = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; sd_tx_valid = 1'b0; sd_tx_data = '0; uart_tx_busy = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = '0; rx_ack = 1'b0;
`ifdef UART_TX_SCHED_LOOPBACK_EN
    loopback = 1'b0;
`endif
    step(2);
    chk("rst_ready", {7'b0, sd_tx_ready}, 8'h01);
    chk("rst_status", status, 8'h04);
    chk("rst_start", {7'b0, uart_tx_start}, 8'h00);
    chk("rst_rxdata", rx_data_out, 8'h00);
    rst = 1'b0;
    step(1);
    chk("rst_status_wr", {7'b0, status_wr}, 8'h00);

    // Single word A5, transmitter busy from 1 cycle after start for 10 cycles
    sd_tx_valid = 1'b1; sd_tx_data = 8'hA5;
    step(1);
    sd_tx_valid = 1'b0;
    chk("a5_nostart_n1", {7'b0, uart_tx_start}, 8'h00);
    chk("a5_status_n1", status, 8'h00);
    step(1);
    chk("a5_start_n2", {7'b0, uart_tx_start}, 8'h01);
    chk("a5_data", uart_tx_data, 8'hA5);
    chk("a5_swr_n2", {7'b0, status_wr}, 8'h01);
    step(1);
    uart_tx_busy = 1'b1;
    chk("a5_start_n3", {7'b0, uart_tx_start}, 8'h00);
    chk("a5_swr_n3", {7'b0, status_wr}, 8'h01);
    step(1);
    chk("a5_status_sending", status, 8'h06);
    chk("a5_swr_n4", {7'b0, status_wr}, 8'h00);
    step(1);
    chk("a5_swr_n5", {7'b0, status_wr}, 8'h01);
    step(8);
    uart_tx_busy = 1'b0;
    chk("a5_status_n13", status, 8'h06);
    chk("a5_data_held", uart_tx_data, 8'hA5);
    step(1);
    chk("a5_status_done", status, 8'h04);
    step(1);
    chk("a5_swr_done", {7'b0, status_wr}, 8'h01);

    // F0 occupies the transmitter (busy stuck), then 01..04 fill the FIFO; 05 is refused
    uart_tx_busy = 1'b1;
    sd_tx_valid = 1'b1; sd_tx_data = 8'hF0;
    step(1);
    sd_tx_valid = 1'b0;
    step(1);
    chk("f0_data", uart_tx_data, 8'hF0);
    step(1);
    for (int i = 1; i <= 4; i++) begin
      sd_tx_valid = 1'b1; sd_tx_data = 8'(i);
      step(1);
    end
    chk("full_ready", {7'b0, sd_tx_ready}, 8'h00);
    chk("full_status", status, 8'h0A);
    sd_tx_data = 8'h05;
    step(1);
    sd_tx_valid = 1'b0;
    chk("full_ready_held", {7'b0, sd_tx_ready}, 8'h00);
    uart_tx_busy = 1'b0;
    expect_tx("w01", 8'h01);
    expect_tx("w02", 8'h02);
    expect_tx("w03", 8'h03);
    expect_tx("w04", 8'h04);
    wait_start(seen);
    chk("no_w05", {7'b0, seen}, 8'h00);
    chk("drained_status", status, 8'h04);
    chk("drained_ready", {7'b0, sd_tx_ready}, 8'h01);

    // Busy never rises for B1; B2 is queued behind it
    sd_tx_valid = 1'b1; sd_tx_data = 8'hB1;
    step(1);
    sd_tx_data = 8'hB2;
    step(1);
    sd_tx_valid = 1'b0;
    chk("b1_start", {7'b0, uart_tx_start}, 8'h01);
    chk("b1_data", uart_tx_data, 8'hB1);
    step(1);
    step(15);
    chk("to_err_before", {7'b0, status[5]}, 8'h00);
    step(1);
    chk("to_err_at", {7'b0, status[5]}, 8'h01);
    step(1);
    chk("b2_start", {7'b0, uart_tx_start}, 8'h01);
    chk("b2_data", uart_tx_data, 8'hB2);
    step(1);
    uart_tx_busy = 1'b1;
    step(1);
    uart_tx_busy = 1'b0;
    chk("b2_sending", {7'b0, status[1]}, 8'h01);
    step(3);
    chk("to_err_sticky", status, 8'h24);

    // RX overrun
    uart_rx_valid = 1'b1; uart_rx_data = 8'h3C;
    step(1);
    uart_rx_valid = 1'b0;
    chk("rx_3c_data", rx_data_out, 8'h3C);
    chk("rx_3c_flags", {6'b0, status[4], status[0]}, 8'h01);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
    step(1);
    uart_rx_valid = 1'b0;
    chk("rx_7e_data", rx_data_out, 8'h7E);
    chk("rx_7e_flags", {6'b0, status[4], status[0]}, 8'h03);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99; rx_ack = 1'b1;
    step(1);
    uart_rx_valid = 1'b0; rx_ack = 1'b0;
    chk("rx_99_data", rx_data_out, 8'h99);
    chk("rx_99_flags", {6'b0, status[4], status[0]}, 8'h03);

    // Reset while SENDING with C2, C3 queued
    uart_tx_busy = 1'b1;
    sd_tx_valid = 1'b1; sd_tx_data = 8'hC1;
    step(1);
    sd_tx_data = 8'hC2;
    step(1);
    sd_tx_data = 8'hC3;
    step(1);
    sd_tx_valid = 1'b0;
    step(1);
    chk("c_sending", {6'b0, status[2], status[1]}, 8'h01);
    rst = 1'b1;
    #1;
    chk("arst_status", status, 8'h04);
    chk("arst_ready", {7'b0, sd_tx_ready}, 8'h01);
    chk("arst_txdata", uart_tx_data, 8'h00);
    chk("arst_rxdata", rx_data_out, 8'h00);
    chk("arst_swr", {7'b0, status_wr}, 8'h00);
    uart_tx_busy = 1'b0;
    step(1);
    rst = 1'b0;
    wait_start(seen);
    chk("arst_no_start", {7'b0, seen}, 8'h00);
    chk("arst_status_after", status, 8'h04);

    // Same-cycle RX valid and ack raises no overrun
    uart_rx_valid = 1'b1; uart_rx_data = 8'h11;
    step(1);
    uart_rx_data = 8'h22; rx_ack = 1'b1;
    step(1);
    uart_rx_valid = 1'b0; rx_ack = 1'b0;
    chk("rx_same_data", rx_data_out, 8'h22);
    chk("rx_same_flags", {6'b0, status[4], status[0]}, 8'h01);
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    chk("rx_ack_clear", {6'b0, status[4], status[0]}, 8'h00);

`ifdef UART_TX_SCHED_LOOPBACK_EN
    loopback = 1'b1;
    uart_rx_valid = 1'b1; uart_rx_data = 8'hEE;
    sd_tx_valid = 1'b1; sd_tx_data = 8'h5A;
    step(1);
    sd_tx_valid = 1'b0;
    step(1);
    chk("lb_start", {7'b0, uart_tx_start}, 8'h01);
    chk("lb_rx_before", rx_data_out, 8'h22);
    step(1);
    chk("lb_rx_data", rx_data_out, 8'h5A);
    chk("lb_rx_flag", {7'b0, status[0]}, 8'h01);
    uart_rx_valid = 1'b0;
    loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
